dmem_host_ctrl: RTL and testbench

- Host-side sequencer directly upstream of the multicore top level.
- Streams matrix operands into data memory over the testbench write path (current_addr / write_from_tb / mem_data) and raises START.
- Waits for END, then reads the result block back through the ar_in read path and streams it out.
- Replaces hand-written testbench load/unload loops with one synthesizable block usable on the FPGA.

---
 rtl/dmem_host_ctrl_pkg.sv | 24 ++
 rtl/dmem_host_ctrl_word_addr_counter.sv | 30 +++
 rtl/dmem_host_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dmem_host_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_host_ctrl_pkg.sv
// Shared types and constants for the data-memory host sequencer.
// The state list includes ERROR, which is only reachable when the
// END watchdog (DMEM_HOST_CTRL_TIMEOUT_EN) is compiled in.
package dmem_host_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    KICK    = 4'd2,
    RUN     = 4'd3,
    RD_REQ  = 4'd4,
    RD_WAIT = 4'd5,
    RD_CAP  = 4'd6,
    STREAM  = 4'd7,
    DONE    = 4'd8,
    ERROR   = 4'd9
  } state_t;

  // Top-level data-memory address mux selections.
  localparam logic [1:0] SEL_CORE  = 2'b00;
  localparam logic [1:0] SEL_WRITE = 2'b01;
  localparam logic [1:0] SEL_READ  = 2'b10;

endpackage

// File: rtl/dmem_host_ctrl_word_addr_counter.sv
// Word offset counter used for both the load and the read-back walks.
// addr = base + offset (modulo 2^16); last flags offset == last_idx.
module word_addr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base,
  input  logic [15:0] last_idx,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] addr,
  output logic        last
);

  logic [15:0] count;

  // Offset register; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (inc) begin
      count <= count + 16'd1;
    end
  end

  assign addr = base + count;
  assign last = (count == last_idx);

endmodule

// File: rtl/dmem_host_ctrl.sv
// Host-side sequencer: loads operands into data memory, kicks the cores,
// waits for END, then reads the result block back and streams it out.
// Optional END watchdog enabled by defining DMEM_HOST_CTRL_TIMEOUT_EN.
module dmem_host_ctrl
  import dmem_host_ctrl_pkg::*;
#(
  parameter logic [15:0] LOAD_BASE      = 16'd0,
  parameter int unsigned LOAD_WORDS     = 64,
  parameter logic [15:0] RES_BASE       = 16'd128,
  parameter int unsigned RES_WORDS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        go,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic [15:0] current_addr,
  output logic [15:0] mem_data,
  output logic        write_from_tb,
  output logic [1:0]  addr_mux_select,
  output logic [15:0] ar_in,
  output logic        START,
  input  logic        END,
  input  logic [15:0] dmem_rdata,
  output logic        m_valid,
  output logic [15:0] m_data,
  input  logic        m_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] LOAD_LAST = 16'(LOAD_WORDS - 32'd1);
  localparam logic [15:0] RES_LAST  = 16'(RES_WORDS - 32'd1);

  state_t      state;
  logic        load_flush;  // final load write is on the bus this cycle
  logic [15:0] load_addr;
  logic [15:0] res_addr;
  logic        load_last;
  logic        res_last;
  logic        load_hs;
  logic        res_hs;
  logic        cnt_clear;

  assign load_hs   = (state == LOAD) && s_valid && s_ready;
  assign res_hs    = (state == STREAM) && m_ready;
  assign cnt_clear = (state == DONE);

  word_addr_counter u_load_cnt (
    .clk      (clk),
    .rst      (RESET),
    .base     (LOAD_BASE),
    .last_idx (LOAD_LAST),
    .clear    (cnt_clear),
    .inc      (load_hs),
    .addr     (load_addr),
    .last     (load_last)
  );

  word_addr_counter u_res_cnt (
    .clk      (clk),
    .rst      (RESET),
    .base     (RES_BASE),
    .last_idx (RES_LAST),
    .clear    (cnt_clear),
    .inc      (res_hs),
    .addr     (res_addr),
    .last     (res_last)
  );

`ifdef DMEM_HOST_CTRL_TIMEOUT_EN
  logic [31:0] run_cnt;
`else
  assign err = 1'b0;
`endif

  // Session sequencer: state plus every registered output.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state           <= IDLE;
      load_flush      <= 1'b0;
      s_ready         <= 1'b0;
      current_addr    <= 16'd0;
      mem_data        <= 16'd0;
      write_from_tb   <= 1'b0;
      addr_mux_select <= SEL_WRITE;
      ar_in           <= 16'd0;
      START           <= 1'b0;
      m_valid         <= 1'b0;
      m_data          <= 16'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef DMEM_HOST_CTRL_TIMEOUT_EN
      run_cnt         <= 32'd0;
      err             <= 1'b0;
`endif
    end else begin
      write_from_tb <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            s_ready <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (load_flush) begin
            // Last write has issued on the write path; switch mux to the core.
            load_flush      <= 1'b0;
            addr_mux_select <= SEL_CORE;
            state           <= KICK;
          end else if (s_valid && s_ready) begin
            write_from_tb <= 1'b1;
            current_addr  <= load_addr;
            mem_data      <= s_data;
            if (load_last) begin
              s_ready    <= 1'b0;
              load_flush <= 1'b1;
            end
          end
        end
        KICK: begin
          // Mux already at core for one cycle; now release the cores.
          START <= 1'b1;
`ifdef DMEM_HOST_CTRL_TIMEOUT_EN
          run_cnt <= 32'd0;
`endif
          state <= RUN;
        end
        RUN: begin
          if (END) begin
            START           <= 1'b0;
            addr_mux_select <= SEL_READ;
            state           <= RD_REQ;
          end
`ifdef DMEM_HOST_CTRL_TIMEOUT_EN
          else if (run_cnt == TIMEOUT_CYCLES - 32'd1) begin
            START           <= 1'b0;
            addr_mux_select <= SEL_WRITE;
            err             <= 1'b1;
            state           <= ERROR;
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
`endif
        end
        RD_REQ: begin
          ar_in <= res_addr;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Covers the data-memory read latency.
          state <= RD_CAP;
        end
        RD_CAP: begin
          m_data  <= dmem_rdata;
          m_valid <= 1'b1;
          state   <= STREAM;
        end
        STREAM: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (res_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= RD_REQ;
            end
          end
        end
        DONE: begin
          addr_mux_select <= SEL_WRITE;
          busy            <= 1'b0;
          state           <= IDLE;
        end
`ifdef DMEM_HOST_CTRL_TIMEOUT_EN
        ERROR: begin
          // Sticky until RESET; err and busy stay high.
          state <= ERROR;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_host_ctrl.sv
// Self-checking bench for dmem_host_ctrl: table-driven and random sessions
// checked against a word-level model of load, kick, run and read-back.
module tb_dmem_host_ctrl;
  import dmem_host_ctrl_pkg::*;

  localparam int          LW = 4;
  localparam int          RW = 2;
  localparam logic [15:0] LB = 16'd0;
  localparam logic [15:0] RB = 16'd128;

  logic clk = 1'b0;
  logic RESET, go, s_valid, END, m_ready;
  logic [15:0] s_data, dmem_rdata;
  logic s_ready, write_from_tb, START, m_valid, busy, done, err;
  logic [15:0] current_addr, mem_data, ar_in, m_data;
  logic [1:0] addr_mux_select;

  dmem_host_ctrl #(
    .LOAD_BASE(LB), .LOAD_WORDS(LW), .RES_BASE(RB), .RES_WORDS(RW), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .RESET(RESET), .go(go), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .current_addr(current_addr), .mem_data(mem_data),
    .write_from_tb(write_from_tb), .addr_mux_select(addr_mux_select), .ar_in(ar_in),
    .START(START), .END(END), .dmem_rdata(dmem_rdata), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Result region of data memory, one-cycle registered read.
  logic [15:0] res0, res1;
  always @(posedge clk) begin
    dmem_rdata <= (ar_in == RB) ? res0 : ((ar_in == RB + 16'd1) ? res1 : 16'hDEAD);
  end

  // Passive monitor: logs bus events for the main sequence to compare.
  logic [15:0] wl_addr[$], wl_data[$], ar_log[$], m_log[$];
  int wmux_bad = 0, done_cnt = 0, start_cnt = 0, kick_cnt = 0, stab_bad = 0;
  logic [15:0] prev_ar = 16'd0, prev_md = 16'd0;
  logic prev_mv = 1'b0, prev_mr = 1'b0;
  always @(negedge clk) begin
    if (write_from_tb) begin
      wl_addr.push_back(current_addr);
      wl_data.push_back(mem_data);
      if (addr_mux_select != SEL_WRITE) wmux_bad <= wmux_bad + 1;
    end
    if (ar_in != prev_ar) ar_log.push_back(ar_in);
    if (m_valid && m_ready) m_log.push_back(m_data);
    if (done) done_cnt <= done_cnt + 1;
    if (START) start_cnt <= start_cnt + 1;
    if (addr_mux_select == SEL_CORE && !START) kick_cnt <= kick_cnt + 1;
    if (prev_mv && !prev_mr && !RESET &&
        (!m_valid || m_data != prev_md || ar_in != prev_ar)) stab_bad <= stab_bad + 1;
    prev_ar <= ar_in;
    prev_md <= m_data;
    prev_mv <= m_valid;
    prev_mr <= m_ready;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0][15:0] w;
    int gap;        // 0 continuous, 1 alternate, 2 random s_valid
    int end_delay;
    int bp;
    logic [15:0] r0, r1;
    bit go_in_run;
    bit end_early;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, b, c, d, input int gap, ed, bp,
                              input logic [15:0] r0, r1, input bit gir, ee);
    vec_t v;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
    v.gap = gap; v.end_delay = ed; v.bp = bp; v.r0 = r0; v.r1 = r1;
    v.go_in_run = gir; v.end_early = ee;
    return v;
  endfunction

  task automatic go_pulse(input bit end_early);
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0; END = end_early;
  endtask

  task automatic drive_load(input logic [3:0][15:0] w, input int gap, output bit ok);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < LW && cyc < 200) begin
      if (gap == 0) s_valid = 1'b1;
      else if (gap == 1) s_valid = (cyc % 2 == 1);
      else s_valid = ($urandom_range(0, 1) == 1);
      s_data = w[idx];
      @(negedge clk); acc = s_valid && s_ready;
      @(posedge clk); #1;
      END = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    ok = (idx == LW);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (START) ok = 1'b1;
    end
  endtask

  task automatic run_session(input vec_t v);
    int w0, a0, m0, d0, s0, k0, b0, wb0;
    bit ok;
    logic [15:0] exp_r [RW];
    exp_r[0] = v.r0; exp_r[1] = v.r1;
    res0 = v.r0; res1 = v.r1;
    w0 = wl_addr.size(); a0 = ar_log.size(); m0 = m_log.size();
    d0 = done_cnt; s0 = start_cnt; k0 = kick_cnt; b0 = stab_bad; wb0 = wmux_bad;
    go_pulse(v.end_early);
    drive_load(v.w, v.gap, ok);
    chk("load_accepts_all", 32'(ok), 32'd1);
    wait_start(ok);
    chk("start_rises", 32'(ok), 32'd1);
    if (!ok) return;
    if (v.go_in_run) go = 1'b1;
    repeat (v.end_delay) begin @(posedge clk); #1; end
    END = 1'b1;
    @(posedge clk); #1 END = 1'b0; go = 1'b0;
    for (int k = 0; k < RW; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        if (m_valid) ok = 1'b1;
        else begin @(posedge clk); #1; end
      end
      chk("m_valid_arrives", 32'(ok), 32'd1);
      if (!ok) return;
      repeat ((k == 0) ? v.bp : v.bp % 3) begin @(posedge clk); #1; end
      m_ready = 1'b1;
      @(posedge clk); #1 m_ready = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("write_count", 32'(wl_addr.size() - w0), 32'(LW));
    if (wl_addr.size() - w0 == LW)
      for (int i = 0; i < LW; i++) begin
        chk("write_addr", 32'(wl_addr[w0 + i]), 32'(LB + 16'(i)));
        chk("write_data", 32'(wl_data[w0 + i]), 32'(v.w[i]));
      end
    chk("write_mux_is_01", 32'(wmux_bad - wb0), 32'd0);
    chk("kick_cycles", 32'(kick_cnt - k0), 32'd1);
    chk("start_high_cycles", 32'(start_cnt - s0), 32'(v.end_delay + 1));
    chk("ar_count", 32'(ar_log.size() - a0), 32'(RW));
    if (ar_log.size() - a0 == RW)
      for (int i = 0; i < RW; i++) chk("ar_in", 32'(ar_log[a0 + i]), 32'(RB + 16'(i)));
    chk("m_count", 32'(m_log.size() - m0), 32'(RW));
    if (m_log.size() - m0 == RW)
      for (int i = 0; i < RW; i++) chk("m_data", 32'(m_log[m0 + i]), 32'(exp_r[i]));
    chk("m_stable_under_bp", 32'(stab_bad - b0), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_mux", 32'(addr_mux_select), 32'(SEL_WRITE));
    chk("idle_start", 32'(START), 32'd0);
    chk("idle_s_ready", 32'(s_ready), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write"}, 32'(write_from_tb), 32'd0);
    chk({tag, "_start"}, 32'(START), 32'd0);
    chk({tag, "_mux"}, 32'(addr_mux_select), 32'(SEL_WRITE));
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_outs"}, {m_valid, done, err, 13'd0, current_addr}, 32'd0);
  endtask

  vec_t tbl[3];

  initial begin
    bit ok;
    tbl[0] = mk(16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 50, 0, 16'hBEEF, 16'h1234, 1'b0, 1'b0);
    tbl[1] = mk(16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4, 1, 5, 10, 16'hBEEF, 16'h1234, 1'b0, 1'b1);
    tbl[2] = mk(16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 0, 0, 3, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    RESET = 1'b1; go = 1'b0; s_valid = 1'b0; s_data = 16'd0; END = 1'b0; m_ready = 1'b0;
    res0 = 16'd0; res1 = 16'd0;
    #1 chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;

    for (int i = 0; i < 3; i++) run_session(tbl[i]);

    // RESET in the middle of a load abandons it; next session restarts at LOAD_BASE.
    go_pulse(1'b0);
    s_valid = 1'b1; s_data = 16'h5A5A;
    repeat (2) @(posedge clk);
    #2 RESET = 1'b1;
    #1 chk_reset_outputs("midload_async");
    s_valid = 1'b0;
    @(negedge clk) chk_reset_outputs("midload");
    @(posedge clk); #1 RESET = 1'b0;
    run_session(tbl[0]);

    for (int n = 0; n < 6; n++) begin
      vec_t v;
      v = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2,
             $urandom_range(0, 30), $urandom_range(0, 5), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_session(v);
    end

`ifdef DMEM_HOST_CTRL_TIMEOUT_EN
    // Watchdog: END never arrives.
    go_pulse(1'b0);
    drive_load(tbl[0].w, 0, ok);
    wait_start(ok);
    chk("to_start_rises", 32'(ok), 32'd1);
    repeat (19) begin @(posedge clk); #1; end
    chk("to_err_before", 32'(err), 32'd0);
    chk("to_start_before", 32'(START), 32'd1);
    @(posedge clk); #1;
    chk("to_err", 32'(err), 32'd1);
    chk("to_start_low", 32'(START), 32'd0);
    chk("to_mux", 32'(addr_mux_select), 32'(SEL_WRITE));
    repeat (5) @(posedge clk);
    #1;
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_busy_sticky", 32'(busy), 32'd1);
    RESET = 1'b1;
    #1 chk("to_err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1 RESET = 1'b0;
`else
    ok = 1'b0;
    chk("err_tied_low", 32'(err), 32'(ok));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
